// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine over a 128-bit state.
// Transforms COLS_PER_CYCLE columns per BUSY cycle in place, with valid/ready on both sides.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit ENABLE_INV     = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int NB = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_BEAT = 2'(NB - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    beat_q;
  logic [127:0]  work_q, work_d;
  logic [127:0]  out_state_q;
  logic          inv_q;
  logic [6:0]    col_lsb;
  logic [31:0]   col_in;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse coefficients built from an x2 -> x4 -> x8 xtime chain.
  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

  // Column 0 sits in the top 32 bits, so column idx starts at bit 32*(3-idx).
  always_comb begin
    work_d  = work_q;
    col_lsb = '0;
    col_in  = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_lsb = 7'(32 * (3 - (int'(beat_q) * COLS_PER_CYCLE + j)));
      col_in  = work_q[col_lsb +: 32];
      work_d[col_lsb +: 32] = (ENABLE_INV && inv_q) ? mix_inv(col_in) : mix_fwd(col_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_d = in_bypass ? DONE : BUSY;
      end
      BUSY: begin
        if (beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // out_state has its own register so it survives the next capture into work_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q      <= '0;
      beat_q      <= '0;
      inv_q       <= 1'b0;
      out_state_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q <= in_state;
            inv_q  <= in_inv & ENABLE_INV;
            beat_q <= '0;
            if (in_bypass) out_state_q <= in_state;
          end
        end
        BUSY: begin
          work_q <= work_d;
          beat_q <= beat_q + 2'd1;
          if (beat_q == LAST_BEAT) out_state_q <= work_d;
        end
        default: ;
      endcase
    end
  end

  assign out_state = out_state_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench for mix_columns_engine: three instances (1, 2 and 4 columns per cycle)
// share stimulus; a GF(2^8) matrix model supplies expected results.
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_inv;
  logic         in_bypass;
  logic         out_ready;
  logic         in_ready_a [3];
  logic         out_valid_a [3];
  logic [127:0] out_state_a [3];

  int checks = 0;
  int passed = 0;
  bit rand_ready = 1'b0;
  bit accept_ok;

  logic [127:0] q0 [$];
  logic [127:0] q1 [$];
  logic [127:0] q2 [$];

  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1), .ENABLE_INV(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .in_state(in_state), .in_inv(in_inv), .in_bypass(in_bypass),
    .out_valid(out_valid_a[0]), .out_ready(out_ready), .out_state(out_state_a[0]));

  mix_columns_engine #(.COLS_PER_CYCLE(2), .ENABLE_INV(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .in_state(in_state), .in_inv(in_inv), .in_bypass(in_bypass),
    .out_valid(out_valid_a[1]), .out_ready(out_ready), .out_state(out_state_a[1]));

  mix_columns_engine #(.COLS_PER_CYCLE(4), .ENABLE_INV(1'b1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[2]),
    .in_state(in_state), .in_inv(in_inv), .in_bypass(in_bypass),
    .out_valid(out_valid_a[2]), .out_ready(out_ready), .out_state(out_state_a[2]));

  // Reference model: generic GF(2^8) product and a rotated-coefficient matrix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] refMix(input logic [127:0] s, input bit inv);
    logic [7:0]   base [4];
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) m[k] = 8'(s >> (120 - 32 * c - 8 * k));
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - r + 4) % 4], m[k]);
        res = {res[119:0], acc};
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic popCompare(input int i, input logic [127:0] actual);
    logic [127:0] e;
    int sz;
    case (i)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      checks++;
      $display("[TB] FAIL unexpected_output_dut%0d: got %h, expected no output", i, actual);
    end else begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      checkOutput($sformatf("result_dut%0d", i), actual, e);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++)
        if (out_valid_a[i] && out_ready) popCompare(i, out_state_a[i]);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offers a state only when all three engines are ready so they stay in lockstep.
  task automatic applyStimulus(input logic [127:0] s, input bit inv, input bit byp,
                               input logic [127:0] exp, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready_a[0] && in_ready_a[1] && in_ready_a[2]) begin
        in_valid  = 1'b1;
        in_state  = s;
        in_inv    = inv;
        in_bypass = byp;
        q0.push_back(exp);
        q1.push_back(exp);
        q2.push_back(exp);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got in_ready low for 300 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_state  = rand128();
    in_inv    = 1'($urandom_range(0, 1));
    in_bypass = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
    end
    checkOutput("drain_pending", 128'(q0.size() + q1.size() + q2.size()), 128'd0);
  endtask

  task automatic latencyTest(input logic [127:0] s, input bit inv, input bit byp,
                             input logic [127:0] exp, input int l0, input int l1, input int l2);
    int lat [3];
    int hold_bad [3];
    int want [3];
    logic [127:0] snap [3];
    want[0] = l0; want[1] = l1; want[2] = l2;
    for (int i = 0; i < 3; i++) begin lat[i] = 0; hold_bad[i] = 0; end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(s, inv, byp, exp, accept_ok);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (lat[i] == 0 && out_valid_a[i]) lat[i] = n;
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("latency_dut%0d", i), 128'(lat[i]), 128'(want[i]));
      snap[i] = out_state_a[i];
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (out_state_a[i] !== snap[i] || out_valid_a[i] !== 1'b1 || in_ready_a[i] !== 1'b0)
          hold_bad[i]++;
    end
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("hold_stable_dut%0d", i), 128'(hold_bad[i]), 128'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain();
  endtask

  initial begin
    logic [127:0] va, va_f, vb, vb_f, vc, s, y;
    bit inv;

    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_inv = 1'b0; in_bypass = 1'b0; out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_in_ready_dut%0d", i), 128'(in_ready_a[i]), 128'd0);
      checkOutput($sformatf("reset_out_valid_dut%0d", i), 128'(out_valid_a[i]), 128'd0);
      checkOutput($sformatf("reset_out_state_dut%0d", i), out_state_a[i], 128'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("idle_in_ready_dut%0d", i), 128'(in_ready_a[i]), 128'd1);

    // Published FIPS-197 columns placed in shifting column positions.
    out_ready = 1'b1;
    va   = {32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'h01010101};
    va_f = {32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'h01010101};
    vb   = {32'hc6c6c6c6, 32'hdb135345, 32'hf20a225c, 32'h2d26314c};
    vb_f = {32'hc6c6c6c6, 32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8};
    vc   = {32'h01010101, 32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6};
    applyStimulus(va,   1'b0, 1'b0, va_f, accept_ok);
    applyStimulus(vb,   1'b0, 1'b0, vb_f, accept_ok);
    applyStimulus(va_f, 1'b1, 1'b0, va,   accept_ok);
    applyStimulus(vb_f, 1'b1, 1'b0, vb,   accept_ok);
    applyStimulus(vc,   1'b0, 1'b0, vc,   accept_ok);
    applyStimulus(vc,   1'b1, 1'b0, vc,   accept_ok);
    waitDrain();

    s = rand128();
    latencyTest(s, 1'b0, 1'b0, refMix(s, 1'b0), 5, 3, 2);
    s = rand128();
    latencyTest(s, 1'b1, 1'b1, s, 1, 1, 1);

    // Reset while the single-column engine is on beat 1.
    s = rand128();
    applyStimulus(s, 1'b0, 1'b0, refMix(s, 1'b0), accept_ok);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("rst_in_ready_dut%0d", i), 128'(in_ready_a[i]), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("post_rst_in_ready_dut%0d", i), 128'(in_ready_a[i]), 128'd1);
      checkOutput($sformatf("post_rst_out_valid_dut%0d", i), 128'(out_valid_a[i]), 128'd0);
    end
    checkOutput("post_rst_out_state_dut0", out_state_a[0], 128'd0);
    s = rand128();
    applyStimulus(s, 1'b1, 1'b0, refMix(s, 1'b1), accept_ok);
    waitDrain();

    // Random traffic with output stalls; each pair is a forward/inverse round trip.
    rand_ready = 1'b1;
    for (int n = 0; n < 500; n++) begin
      s   = rand128();
      inv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        applyStimulus(s, inv, 1'b1, s, accept_ok);
      end else begin
        y = refMix(s, inv);
        applyStimulus(s, inv, 1'b0, y, accept_ok);
        applyStimulus(y, !inv, 1'b0, s, accept_ok);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
